// File: rtl/serial_adder_if.sv
// Requester <-> bit-serial adder handshake: operands and start in, result and status back.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic             op;
  logic             ci;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (output start, op, ci, a, b, input busy, done, s, co, ovf);
  modport slave  (input start, op, ci, a, b, output busy, done, s, co, ovf);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walks a WIDTH-bit operand pair LSB first,
// one bit per clock. The result is published only when the last bit is done.
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a, sh_b, acc, s_q;
  logic [CW-1:0]    cnt;
  logic             carry, co_q, ovf_q;
  logic             fa_sum, fa_cout;

  serial_adder_fa u_fa (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // Subtract is a + ~b + 1: invert b up front, seed the carry with 1.
            sh_a  <= bus.a;
            sh_b  <= bus.op ? ~bus.b : bus.b;
            carry <= bus.op ? 1'b1 : bus.ci;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          acc   <= {fa_sum, acc[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here
            s_q   <= {fa_sum, acc[WIDTH-1:1]};
            co_q  <= fa_cout;
            ovf_q <= fa_cout ^ carry;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized scoreboard bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [W-1:0] last_s = '0;
  exp_t q[$];

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci);
    exp_t e;
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cin;
    bb   = op ? ~b : b;
    cin  = op ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    e.s   = full[W-1:0];
    e.co  = full[W];
    e.ovf = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: checks results on done, and that s holds its old value during RUN.
  int busy_run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        busy_run++;
        chk("s_hold", bus.s, last_s);
        chk("no_done_while_busy", bus.done, 1'b0);
      end
      if (bus.done) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("s", bus.s, e.s);
          chk("co", bus.co, e.co);
          chk("ovf", bus.ovf, e.ovf);
          chk("latency", cyc - e.cyc, W);
          chk("busy_cycles", busy_run, W);
          last_s = e.s;
        end
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci);
    exp_t e;
    int t = 0;
    while (bus.busy) begin
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        checks++; failures++;
        $display("FAIL busy_timeout actual=1 required=0");
        return;
      end
    end
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.ci = ci;
    @(posedge clk); #1;
    e = model(op, a, b, ci);
    e.cyc = cyc;
    q.push_back(e);
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
      q.delete();
    end
    idle(1);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_s"}, bus.s, '0);
    chk({tag, "_co"}, bus.co, 1'b0);
    chk({tag, "_ovf"}, bus.ovf, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
    #3;
    reset_check("rst_init");
    idle(2);
    rst = 1'b0;
    idle(1);

    // Directed cases
    issue(1'b0, 8'hFF, 8'h01, 1'b0);
    wait_drain();
    issue(1'b0, 8'h5A, 8'h33, 1'b1);
    wait_drain();
    issue(1'b1, 8'h10, 8'h20, 1'b1);
    issue(1'b1, 8'h80, 8'h01, 1'b0);
    wait_drain();

    // start pulsed mid-RUN must be ignored
    issue(1'b0, 8'h12, 8'h34, 1'b0);
    idle(3);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 8'h00; bus.b = 8'h00; bus.ci = 1'b1;
    idle(1);
    bus.start = 1'b0;
    wait_drain();

    // Back-to-back chain
    for (int i = 0; i < 4; i++)
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    wait_drain();

    // Reset at bit 4 of a running op: discarded, outputs cleared at once
    issue(1'b0, 8'h77, 8'h11, 1'b1);
    idle(4);
    #1 rst = 1'b1;
    #1;
    reset_check("rst_mid");
    q.delete();
    last_s = '0;
    idle(2);
    chk("rst_hold_done", bus.done, 1'b0);
    rst = 1'b0;
    idle(1);
    issue(1'b0, 8'h01, 8'h02, 1'b0);
    wait_drain();

    // Randomized traffic with random gaps and stray starts
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 5));
        if (bus.busy) begin
          bus.start = 1'b1; bus.a = 8'($urandom); bus.b = 8'($urandom);
          idle(1);
          bus.start = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        wait_drain();
        idle($urandom_range(0, 3));
      end
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
